// File: rtl/gat_bram_load_ctrl.sv
// BRAM load/readback controller for gat_top: streams host data into NUM_CH BRAMs and streams the feature BRAM back out.
// Optional GAT_LOAD_CHECKSUM_EN adds o_load_sum, a running sum of the beats written by the current command.
`timescale 1ns/1ps
module gat_bram_load_ctrl #(
    parameter int NUM_CH      = 3,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 18,
    parameter int FEAT_W      = 8,
    parameter int FEAT_ADDR_W = 16,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_layer_clr,
    input  logic                   i_cfg_vld,
    output logic                   o_cfg_rdy,
    input  logic [CH_W-1:0]        i_cfg_ch,
    input  logic [ADDR_W:0]        i_cfg_len,
    input  logic                   i_s_vld,
    output logic                   o_s_rdy,
    input  logic [DATA_W-1:0]      i_s_data,
    output logic [DATA_W-1:0]      o_bram_din,
    output logic [ADDR_W-1:0]      o_bram_addra,
    output logic [NUM_CH-1:0]      o_bram_ena,
    output logic [NUM_CH-1:0]      o_bram_wea,
    output logic [NUM_CH-1:0]      o_load_done,
    output logic                   o_all_done,
    output logic                   o_err_len,
    input  logic                   i_rd_start,
    input  logic [FEAT_ADDR_W:0]   i_rd_len,
    output logic                   o_rd_busy,
    output logic [FEAT_ADDR_W-1:0] o_feat_addrb,
    input  logic [FEAT_W-1:0]      i_feat_dout,
    output logic                   o_m_vld,
    input  logic                   i_m_rdy,
    output logic [FEAT_W-1:0]      o_m_data,
    output logic                   o_m_last
`ifdef GAT_LOAD_CHECKSUM_EN
    , output logic [31:0]          o_load_sum
`endif
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {W_IDLE, W_LOAD, W_FIN} wstate_t;
    typedef enum logic {R_IDLE, R_RUN} rstate_t;

    wstate_t             r_wstate, w_wnext;
    logic [CH_W-1:0]     r_ch;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_din;
    logic [ADDR_W-1:0]   r_addra;
    logic [NUM_CH-1:0]   r_ena, r_wea, r_done, w_ch_onehot;
    logic                r_err;
    logic                w_cfg_acc, w_beat, w_last_beat;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_ch_onehot[i] = (r_ch == CH_W'(i));
        end
    end

    assign w_last_beat = ({1'b0, r_addr} == (r_len - (ADDR_W+1)'(1)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_wstate <= W_IDLE;
        else       r_wstate <= w_wnext;
    end

    always_comb begin
        w_wnext   = r_wstate;
        o_cfg_rdy = 1'b0;
        o_s_rdy   = 1'b0;
        w_cfg_acc = 1'b0;
        w_beat    = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                // Ready is masked during reset so every output reads 0 while rst is held.
                o_cfg_rdy = !i_rst;
                w_cfg_acc = i_cfg_vld && !i_rst;
                if (w_cfg_acc) begin
                    if (i_cfg_len == '0)          w_wnext = W_FIN;
                    else if (i_cfg_len > MAX_LEN) w_wnext = W_IDLE;
                    else                          w_wnext = W_LOAD;
                end
            end
            W_LOAD: begin
                o_s_rdy = 1'b1;
                w_beat  = i_s_vld;
                if (w_beat && w_last_beat) w_wnext = W_FIN;
            end
            W_FIN:   w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ch    <= '0;
            r_len   <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_addra <= '0;
            r_ena   <= '0;
            r_wea   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_ena <= '0;
            r_wea <= '0;
            if (w_cfg_acc) begin
                r_ch   <= i_cfg_ch;
                r_len  <= i_cfg_len;
                r_addr <= '0;
                if (i_cfg_len > MAX_LEN) r_err <= 1'b1;
            end
            if (w_beat) begin
                r_din   <= i_s_data;
                r_addra <= r_addr;
                r_ena   <= w_ch_onehot;
                r_wea   <= w_ch_onehot;
                r_addr  <= r_addr + ADDR_W'(1);
            end
            // A FIN set in the same cycle as layer_clr must survive the clear.
            r_done <= (i_layer_clr ? '0 : r_done) | ((r_wstate == W_FIN) ? w_ch_onehot : '0);
        end
    end

    assign o_bram_din   = r_din;
    assign o_bram_addra = r_addra;
    assign o_bram_ena   = r_ena;
    assign o_bram_wea   = r_wea;
    assign o_load_done  = r_done;
    assign o_all_done   = &r_done;
    assign o_err_len    = r_err;

`ifdef GAT_LOAD_CHECKSUM_EN
    logic [31:0] r_sum;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)          r_sum <= '0;
        else if (w_cfg_acc) r_sum <= '0;
        else if (w_beat)    r_sum <= r_sum + 32'(i_s_data);
    end
    assign o_load_sum = r_sum;
`endif

    rstate_t             r_rstate, w_rnext;
    logic [FEAT_ADDR_W:0] r_rlen, r_issue_cnt;
    logic                r_inflight, r_inflight_last;
    logic [FEAT_W-1:0]   r_buf_data [2];
    logic [1:0]          r_buf_last;
    logic [1:0]          r_buf_cnt;
    logic                r_wr_ptr, r_rd_ptr;
    logic [2:0]          w_occ;
    logic                w_pop, w_issue, w_rstart;

    assign o_m_vld      = (r_buf_cnt != 2'd0);
    assign o_m_data     = r_buf_data[r_rd_ptr];
    assign o_m_last     = r_buf_last[r_rd_ptr];
    assign o_rd_busy    = (r_rstate == R_RUN);
    assign o_feat_addrb = r_issue_cnt[FEAT_ADDR_W-1:0];
    assign w_pop        = o_m_vld && i_m_rdy;
    assign w_occ        = {1'b0, r_buf_cnt} + {2'b00, r_inflight};
    assign w_rstart     = (r_rstate == R_IDLE) && i_rd_start && (i_rd_len != '0);
    // Reads in flight reserve a skid slot; a same-cycle pop frees one so 1 beat/cycle is sustained.
    assign w_issue      = (r_rstate == R_RUN) && (r_issue_cnt != r_rlen) &&
                          ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_rstate <= R_IDLE;
        else       r_rstate <= w_rnext;
    end

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_rstart) w_rnext = R_RUN;
            R_RUN:   if (w_pop && o_m_last) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rlen          <= '0;
            r_issue_cnt     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_buf_data[0]   <= '0;
            r_buf_data[1]   <= '0;
            r_buf_last      <= '0;
            r_buf_cnt       <= '0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
        end else begin
            if (w_rstart) begin
                r_rlen      <= i_rd_len;
                r_issue_cnt <= '0;
            end
            if (w_issue) r_issue_cnt <= r_issue_cnt + (FEAT_ADDR_W+1)'(1);
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_issue_cnt == (r_rlen - (FEAT_ADDR_W+1)'(1)));
            if (r_inflight) begin
                r_buf_data[r_wr_ptr] <= i_feat_dout;
                r_buf_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({r_inflight, w_pop})
                2'b10:   r_buf_cnt <= r_buf_cnt + 2'd1;
                2'b01:   r_buf_cnt <= r_buf_cnt - 2'd1;
                default: r_buf_cnt <= r_buf_cnt;
            endcase
        end
    end

endmodule
